// File: rtl/controlpack.sv
// Shared control-word types and bus widths for the address-generation path.
package controlpack;

    localparam int ADDR_BUS_WIDTH = 9;
    localparam int DATA_BUS_WIDTH = 8;

    typedef enum logic [2:0] {
        AR_NOP,
        ABSOLUTE,
        REL_SUB,
        REL_ADD,
        INC
    } addr_register_op_e;

    typedef enum logic {
        MAR,
        PC
    } addr_sel_e;

    typedef enum logic {
        AR_IDLE,
        AR_ABS_HI
    } addr_reg_state_e;

endpackage

// File: rtl/addr_adder.sv
// Combinational next-address arithmetic for INC / REL_ADD / REL_SUB.
module addr_adder
    import controlpack::*;
#(
    parameter int ADDR_W = ADDR_BUS_WIDTH,
    parameter int DATA_W = DATA_BUS_WIDTH
) (
    input  logic [ADDR_W-1:0] operand,
    input  logic [DATA_W-1:0] offset,
    input  logic [2:0]        op,
    output logic [ADDR_W-1:0] next,
    output logic              wrap
);

    logic [ADDR_W:0] base;
    logic [ADDR_W:0] ext;
    logic [ADDR_W:0] res;

    assign base = {1'b0, operand};
    assign ext  = {{(ADDR_W+1-DATA_W){1'b0}}, offset};

    // Bit ADDR_W of the widened result is the carry out or the borrow.
    always_comb begin
        res = base;
        unique case (addr_register_op_e'(op))
            INC:     res = base + {{ADDR_W{1'b0}}, 1'b1};
            REL_ADD: res = base + ext;
            REL_SUB: res = base - ext;
            default: res = base;
        endcase
    end

    assign next = res[ADDR_W-1:0];
    assign wrap = res[ADDR_W];

endmodule

// File: rtl/addr_register_unit.sv
// PC / MAR address registers with two-beat absolute load and relative ops.
module addr_register_unit
    import controlpack::*;
#(
    parameter int ADDR_W = ADDR_BUS_WIDTH,
    parameter int DATA_W = DATA_BUS_WIDTH,
    parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid_i,
    input  logic [2:0]        op_i,
    input  logic              sel_i,
    input  logic              addr_sel_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] mar_o,
    output logic              busy_o,
    output logic              wrap_o,
    output logic              err_o
);

    addr_reg_state_e   state;
    logic [DATA_W-1:0] staging;
    logic              abs_sel;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] mar;
    logic              wrap;
    logic              err;

    logic [ADDR_W-1:0] operand;
    logic [ADDR_W-1:0] next;
    logic              add_wrap;
    logic [ADDR_W-1:0] abs_val;
    addr_register_op_e op;

    assign op      = addr_register_op_e'(op_i);
    assign operand = (sel_i == PC) ? pc : mar;
    assign abs_val = {data_i[ADDR_W-DATA_W-1:0], staging};

    addr_adder #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_adder (
        .operand (operand),
        .offset  (data_i),
        .op      (op_i),
        .next    (next),
        .wrap    (add_wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= AR_IDLE;
            staging <= '0;
            abs_sel <= MAR;
            pc      <= PC_RESET;
            mar     <= '0;
            wrap    <= 1'b0;
            err     <= 1'b0;
        end else begin
            wrap <= 1'b0;
            err  <= 1'b0;
            if (state == AR_ABS_HI) begin
                if (op_valid_i) begin
                    if (abs_sel == PC) pc <= abs_val;
                    else               mar <= abs_val;
                    state <= AR_IDLE;
                end
            end else if (op_valid_i) begin
                unique case (op)
                    AR_NOP: ;
                    ABSOLUTE: begin
                        staging <= data_i;
                        abs_sel <= sel_i;
                        state   <= AR_ABS_HI;
                    end
                    INC, REL_ADD, REL_SUB: begin
                        if (sel_i == PC) pc <= next;
                        else             mar <= next;
                        wrap <= add_wrap;
                    end
                    default: err <= 1'b1;
                endcase
            end
        end
    end

    assign addr_o = (addr_sel_i == PC) ? pc : mar;
    assign pc_o   = pc;
    assign mar_o  = mar;
    assign busy_o = (state == AR_ABS_HI);
    assign wrap_o = wrap;
    assign err_o  = err;

endmodule
